// File: rtl/draw_engine.sv
// Command-driven rasteriser: queued PLOT / FILL_RECT / CLEAR commands become one
// clipped framebuffer write per clock, raster order, x fastest.
module draw_engine #(
   parameter int RESOLUTION_X   = 400,
   parameter int RESOLUTION_Y   = 300,
   parameter int PALETTE_LENGTH = 256,
   parameter int CMD_DEPTH      = 8,
   localparam int XW = $clog2(RESOLUTION_X),
   localparam int YW = $clog2(RESOLUTION_Y),
   localparam int IW = $clog2(PALETTE_LENGTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [XW-1:0] cmd_x0,
   input  logic [XW-1:0] cmd_x1,
   input  logic [YW-1:0] cmd_y0,
   input  logic [YW-1:0] cmd_y1,
   input  logic [IW-1:0] cmd_index,
   input  logic          abort,
   output logic [XW-1:0] fb_wr_x,
   output logic [YW-1:0] fb_wr_y,
   output logic [IW-1:0] fb_wr_index,
   output logic          fb_wr_en,
   output logic          cmd_done,
   output logic          busy,
   output logic [31:0]   pixel_count,
   output logic [15:0]   reject_count,
   output logic [1:0]    dbg_state
);

   localparam int PW = $clog2(CMD_DEPTH);
   localparam logic [XW:0] X_LAST    = (XW+1)'(RESOLUTION_X - 1);
   localparam logic [YW:0] Y_LAST    = (YW+1)'(RESOLUTION_Y - 1);
   localparam logic [PW:0] FIFO_FULL = (PW+1)'(CMD_DEPTH);

   localparam logic [1:0] OP_NOP   = 2'd0;
   localparam logic [1:0] OP_PLOT  = 2'd1;
   localparam logic [1:0] OP_FILL  = 2'd2;
   localparam logic [1:0] OP_CLEAR = 2'd3;

   typedef struct packed {
      logic [1:0]    op;
      logic [XW-1:0] x0;
      logic [XW-1:0] x1;
      logic [YW-1:0] y0;
      logic [YW-1:0] y1;
      logic [IW-1:0] idx;
   } cmd_t;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW} state_t;

   cmd_t          mem_q [CMD_DEPTH];
   cmd_t          mem_d [CMD_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;

   state_t        state_q, state_d;
   cmd_t          cur_q, cur_d;
   logic [XW-1:0] rx0_q, rx0_d, rx1_q, rx1_d;
   logic [YW-1:0] ry1_q, ry1_d;
   logic [XW-1:0] fb_x_q, fb_x_d;
   logic [YW-1:0] fb_y_q, fb_y_d;
   logic [IW-1:0] fb_idx_q, fb_idx_d;
   logic          fb_en_q, fb_en_d;
   logic          done_q, done_d;
   logic [31:0]   pixel_count_q, pixel_count_d;
   logic [15:0]   reject_count_q, reject_count_d;

   logic          fifo_empty, fifo_full, push, pop;
   cmd_t          head, cmd_in;
   logic [XW:0]   reg_x0, reg_x1;
   logic [YW:0]   reg_y0, reg_y1;
   logic          region_empty;

   // Handshake: a command transfers on every rising edge where cmd_valid && cmd_ready;
   // cmd_ready is low while the FIFO is full or abort is asserted, and the producer
   // must hold the command stable until it transfers.
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FIFO_FULL);
   assign cmd_ready  = !fifo_full && !abort;
   assign push       = cmd_valid && cmd_ready;
   assign head       = mem_q[rd_ptr_q];
   assign cmd_in     = '{op: cmd_op, x0: cmd_x0, x1: cmd_x1, y0: cmd_y0, y1: cmd_y1, idx: cmd_index};

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (abort) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = cmd_in;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Region compares run one bit wider than the coordinates so clipping never wraps.
   always_comb begin
      reg_x0 = {1'b0, cur_q.x0};
      reg_x1 = {1'b0, cur_q.x0};
      reg_y0 = {1'b0, cur_q.y0};
      reg_y1 = {1'b0, cur_q.y0};
      case (cur_q.op)
         OP_FILL: begin
            reg_x1 = ({1'b0, cur_q.x1} > X_LAST) ? X_LAST : {1'b0, cur_q.x1};
            reg_y1 = ({1'b0, cur_q.y1} > Y_LAST) ? Y_LAST : {1'b0, cur_q.y1};
         end
         OP_CLEAR: begin
            reg_x0 = '0;
            reg_x1 = X_LAST;
            reg_y0 = '0;
            reg_y1 = Y_LAST;
         end
         default: ;
      endcase
      region_empty = (cur_q.op == OP_NOP) || (reg_x0 > reg_x1) || (reg_y0 > reg_y1) ||
                     (reg_x0 > X_LAST) || (reg_y0 > Y_LAST);
   end

   always_comb begin
      state_d        = state_q;
      cur_d          = cur_q;
      rx0_d          = rx0_q;
      rx1_d          = rx1_q;
      ry1_d          = ry1_q;
      fb_x_d         = fb_x_q;
      fb_y_d         = fb_y_q;
      fb_idx_d       = fb_idx_q;
      fb_en_d        = 1'b0;
      done_d         = 1'b0;
      pixel_count_d  = pixel_count_q;
      reject_count_d = reject_count_q;
      pop            = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               cur_d   = head;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            if (region_empty) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
               if (reject_count_q != 16'hFFFF) reject_count_d = reject_count_q + 16'd1;
            end else begin
               rx0_d         = reg_x0[XW-1:0];
               rx1_d         = reg_x1[XW-1:0];
               ry1_d         = reg_y1[YW-1:0];
               fb_x_d        = reg_x0[XW-1:0];
               fb_y_d        = reg_y0[YW-1:0];
               fb_idx_d      = cur_q.idx;
               fb_en_d       = 1'b1;
               done_d        = (reg_x0 == reg_x1) && (reg_y0 == reg_y1);
               pixel_count_d = pixel_count_q + 32'd1;
               state_d       = S_DRAW;
            end
         end
         S_DRAW: begin
            // The pixel on the outputs this cycle is the one being written.
            if (fb_x_q == rx1_q && fb_y_q == ry1_q) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  cur_d   = head;
                  state_d = S_SETUP;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               fb_en_d       = 1'b1;
               pixel_count_d = pixel_count_q + 32'd1;
               if (fb_x_q == rx1_q) begin
                  fb_x_d = rx0_q;
                  fb_y_d = fb_y_q + 1'b1;
               end else begin
                  fb_x_d = fb_x_q + 1'b1;
               end
               done_d = (fb_x_d == rx1_q) && (fb_y_d == ry1_q);
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (abort) begin
         pop            = 1'b0;
         state_d        = S_IDLE;
         fb_en_d        = 1'b0;
         done_d         = 1'b0;
         fb_x_d         = fb_x_q;
         fb_y_d         = fb_y_q;
         fb_idx_d       = fb_idx_q;
         pixel_count_d  = pixel_count_q;
         reject_count_d = reject_count_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < CMD_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         state_q        <= S_IDLE;
         cur_q          <= '0;
         rx0_q          <= '0;
         rx1_q          <= '0;
         ry1_q          <= '0;
         fb_x_q         <= '0;
         fb_y_q         <= '0;
         fb_idx_q       <= '0;
         fb_en_q        <= 1'b0;
         done_q         <= 1'b0;
         pixel_count_q  <= '0;
         reject_count_q <= '0;
      end else begin
         mem_q          <= mem_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         state_q        <= state_d;
         cur_q          <= cur_d;
         rx0_q          <= rx0_d;
         rx1_q          <= rx1_d;
         ry1_q          <= ry1_d;
         fb_x_q         <= fb_x_d;
         fb_y_q         <= fb_y_d;
         fb_idx_q       <= fb_idx_d;
         fb_en_q        <= fb_en_d;
         done_q         <= done_d;
         pixel_count_q  <= pixel_count_d;
         reject_count_q <= reject_count_d;
      end
   end

   assign fb_wr_x      = fb_x_q;
   assign fb_wr_y      = fb_y_q;
   assign fb_wr_index  = fb_idx_q;
   assign fb_wr_en     = fb_en_q;
   assign cmd_done     = done_q;
   assign busy         = (state_q != S_IDLE) || !fifo_empty;
   assign pixel_count  = pixel_count_q;
   assign reject_count = reject_count_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_draw_engine.sv
// Directed bench for draw_engine: a raster-order event model expands each accepted
// command into its expected writes / reject, and one negedge process checks the DUT.
module tb_draw_engine;

   localparam int RX = 400;
   localparam int RY = 300;
   localparam int XW = 9;
   localparam int YW = 9;
   localparam int IW = 8;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [XW-1:0] cmd_x0, cmd_x1;
   logic [YW-1:0] cmd_y0, cmd_y1;
   logic [IW-1:0] cmd_index;
   logic          abort;
   logic [XW-1:0] fb_wr_x;
   logic [YW-1:0] fb_wr_y;
   logic [IW-1:0] fb_wr_index;
   logic          fb_wr_en;
   logic          cmd_done;
   logic          busy;
   logic [31:0]   pixel_count;
   logic [15:0]   reject_count;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   draw_engine #(
      .RESOLUTION_X(RX), .RESOLUTION_Y(RY), .PALETTE_LENGTH(256), .CMD_DEPTH(8)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
      .cmd_index(cmd_index), .abort(abort),
      .fb_wr_x(fb_wr_x), .fb_wr_y(fb_wr_y), .fb_wr_index(fb_wr_index),
      .fb_wr_en(fb_wr_en), .cmd_done(cmd_done), .busy(busy),
      .pixel_count(pixel_count), .reject_count(reject_count), .dbg_state(dbg_state)
   );

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic          wr;
      logic          done;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic [IW-1:0] idx;
   } ev_t;

   ev_t           ev_q[$];
   int            model_pix = 0;
   int            model_rej = 0;
   logic [XW-1:0] last_x = '0;
   logic [YW-1:0] last_y = '0;
   logic [IW-1:0] last_idx = '0;
   int            n_vec = 0;
   int            n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Expand one accepted command into the writes (or single reject) it must produce.
   task automatic model_add(input logic [1:0] op, input int x0, input int x1,
                            input int y0, input int y1, input int idx);
      int  lx0, lx1, ly0, ly1;
      ev_t e;
      lx0 = x0; lx1 = x0; ly0 = y0; ly1 = y0;
      if (op == 2'd2) begin
         lx1 = (x1 < RX) ? x1 : RX - 1;
         ly1 = (y1 < RY) ? y1 : RY - 1;
      end else if (op == 2'd3) begin
         lx0 = 0; lx1 = RX - 1; ly0 = 0; ly1 = RY - 1;
      end
      if (op == 2'd0 || lx0 > lx1 || ly0 > ly1 || lx0 >= RX || ly0 >= RY) begin
         e      = '0;
         e.done = 1'b1;
         ev_q.push_back(e);
      end else begin
         for (int y = ly0; y <= ly1; y++) begin
            for (int x = lx0; x <= lx1; x++) begin
               e.wr   = 1'b1;
               e.done = (x == lx1) && (y == ly1);
               e.x    = x[XW-1:0];
               e.y    = y[YW-1:0];
               e.idx  = idx[IW-1:0];
               ev_q.push_back(e);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (!reset) begin
         if (fb_wr_en || cmd_done) begin
            check("event_expected", ev_q.size() != 0, 1);
            if (ev_q.size() != 0) begin
               e = ev_q.pop_front();
               check("fb_wr_en", fb_wr_en, e.wr);
               check("cmd_done", cmd_done, e.done);
               if (e.wr) begin
                  check("fb_wr_x", fb_wr_x, e.x);
                  check("fb_wr_y", fb_wr_y, e.y);
                  check("fb_wr_index", fb_wr_index, e.idx);
                  check("busy_while_drawing", busy, 1);
                  model_pix++;
                  last_x   = e.x;
                  last_y   = e.y;
                  last_idx = e.idx;
               end else if (model_rej < 65535) begin
                  model_rej++;
               end
            end
         end
         if (!fb_wr_en) begin
            check("hold_x", fb_wr_x, last_x);
            check("hold_y", fb_wr_y, last_y);
            check("hold_index", fb_wr_index, last_idx);
         end
         check("pixel_count", pixel_count, model_pix);
         check("reject_count", reject_count, model_rej);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [1:0] op, input int x0, input int x1,
                           input int y0, input int y1, input int idx);
      int waited;
      waited    = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_x0    = x0[XW-1:0];
      cmd_x1    = x1[XW-1:0];
      cmd_y0    = y0[YW-1:0];
      cmd_y1    = y1[YW-1:0];
      cmd_index = idx[IW-1:0];
      while (!cmd_ready && waited < 300) begin
         step(1);
         waited++;
      end
      check("push_ready_timeout", waited < 300, 1);
      if (waited >= 300) begin
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      model_add(op, x0, x1, y0, y1, idx);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (ev_q.size() != 0 && n < 2000) begin
         step(1);
         n++;
      end
      check({name, "_drain"}, ev_q.size(), 0);
      check({name, "_busy_idle"}, busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   int t1, t2;

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_x0 = '0; cmd_x1 = '0;
      cmd_y0 = '0; cmd_y1 = '0; cmd_index = '0; abort = 1'b0;
      step(3);
      reset = 1'b0;
      step(1);
      check("rst_fb_wr_en", fb_wr_en, 0);
      check("rst_fb_wr_x", fb_wr_x, 0);
      check("rst_cmd_done", cmd_done, 0);
      check("rst_busy", busy, 0);
      check("rst_pixel_count", pixel_count, 0);
      check("rst_reject_count", reject_count, 0);
      check("rst_cmd_ready", cmd_ready, 1);

      // PLOT (5,7) idx 3: write lands three cycles after acceptance
      push_cmd(2'd1, 5, 0, 7, 0, 3);
      check("plot_n1_en", fb_wr_en, 0);
      step(1);
      check("plot_n2_en", fb_wr_en, 0);
      step(1);
      check("plot_n3_en", fb_wr_en, 1);
      check("plot_n3_x", fb_wr_x, 5);
      check("plot_n3_y", fb_wr_y, 7);
      check("plot_n3_idx", fb_wr_index, 3);
      check("plot_n3_done", cmd_done, 1);
      check("plot_n3_count", pixel_count, 1);
      step(1);
      check("plot_after_en", fb_wr_en, 0);
      check("plot_after_x_hold", fb_wr_x, 5);
      drain("plot");

      // 3x2 fill, then a fill clipped at the bottom-right corner to 2x2
      push_cmd(2'd2, 10, 12, 20, 21, 9);
      drain("fill6");
      check("fill6_count", pixel_count, 7);
      push_cmd(2'd2, 398, 500, 298, 400, 5);
      drain("clip");
      check("clip_count", pixel_count, 11);

      // Rejections: inverted x, NOP, x0 and y0 off-screen
      push_cmd(2'd2, 5, 4, 0, 3, 1);
      step(2);
      check("reject_done", cmd_done, 1);
      check("reject_no_write", fb_wr_en, 0);
      check("reject_count1", reject_count, 1);
      drain("reject");
      push_cmd(2'd0, 1, 1, 1, 1, 1);
      push_cmd(2'd1, 400, 0, 0, 0, 1);
      push_cmd(2'd1, 0, 0, 300, 0, 1);
      drain("reject3");
      check("reject_count4", reject_count, 4);
      check("reject_pix_unchanged", pixel_count, 11);
      push_cmd(2'd1, 399, 0, 299, 0, 255);
      drain("corner");
      check("corner_count", pixel_count, 12);

      // Two queued PLOTs: one bubble between writes
      push_cmd(2'd1, 20, 0, 30, 0, 1);
      push_cmd(2'd1, 21, 0, 30, 0, 2);
      t1 = -1; t2 = -1;
      for (int c = 0; c < 20; c++) begin
         if (fb_wr_en) begin
            if (t1 < 0) t1 = c;
            else if (t2 < 0) t2 = c;
         end
         step(1);
      end
      check("bubble_gap", t2 - t1, 2);
      drain("bubble");
      check("bubble_count", pixel_count, 14);

      // Fill the FIFO behind a 64-pixel fill, then a ninth command
      push_cmd(2'd2, 0, 15, 50, 53, 2);
      step(3);
      for (int i = 0; i < 7; i++) push_cmd(2'd1, 100 + i, 0, 60, 0, 16 + i);
      check("fifo7_ready", cmd_ready, 1);
      push_cmd(2'd1, 107, 0, 60, 0, 23);
      check("fifo8_ready_low", cmd_ready, 0);
      check("fifo8_busy", busy, 1);
      push_cmd(2'd1, 108, 0, 60, 0, 24);
      drain("fifo9");
      check("fifo9_count", pixel_count, 87);

      // CLEAR with a PLOT queued, aborted after 40 writes with a push attempted
      push_cmd(2'd3, 0, 0, 0, 0, 0);
      push_cmd(2'd1, 1, 0, 1, 0, 7);
      step(40);
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_x0 = 9'd2; cmd_y0 = 9'd2; cmd_index = 8'd9;
      abort = 1'b1;
      #1;
      check("abort_ready_low", cmd_ready, 0);
      check("abort_cycle_writing", fb_wr_en, 1);
      @(posedge clk);
      ev_q.delete();
      #1;
      abort = 1'b0;
      cmd_valid = 1'b0;
      check("abort_en_off", fb_wr_en, 0);
      check("abort_no_done", cmd_done, 0);
      check("abort_fifo_empty", busy, 0);
      check("abort_count", pixel_count, 127);
      step(5);
      check("abort_count_kept", pixel_count, 127);
      push_cmd(2'd1, 3, 0, 4, 0, 8'h42);
      drain("post_abort");
      check("post_abort_count", pixel_count, 128);

      // Asynchronous reset in the middle of a CLEAR
      push_cmd(2'd3, 0, 0, 0, 0, 4);
      step(30);
      #1;
      reset = 1'b1;
      ev_q.delete();
      model_pix = 0; model_rej = 0; last_x = '0; last_y = '0; last_idx = '0;
      #1;
      check("arst_en", fb_wr_en, 0);
      check("arst_x", fb_wr_x, 0);
      check("arst_y", fb_wr_y, 0);
      check("arst_idx", fb_wr_index, 0);
      check("arst_done", cmd_done, 0);
      check("arst_busy", busy, 0);
      check("arst_pixel_count", pixel_count, 0);
      check("arst_ready", cmd_ready, 1);
      step(2);
      reset = 1'b0;
      push_cmd(2'd1, 8, 0, 9, 0, 17);
      drain("post_reset");
      check("post_reset_count", pixel_count, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
